// File: rtl/rv_multicycle_ctrl_if.sv
// Control-side bundle for the multi-cycle sequencer: fetch handshake, decode/ALU/RF strobes, status.
// The master modport belongs to the sequencer; the slave modport to memory, ALU and register file.
interface rv_multicycle_ctrl_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     ir;
  logic [XLEN-1:0] pc;
  logic            rf_rd_en;
  logic            alu_src_imm;
  logic            alu_valid;
  logic            alu_ready;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic            busy;
  logic            halted;
  logic            illegal;
  logic [31:0]     instret;

  modport master (
    input  start, imem_ack, imem_rdata, alu_ready,
    output imem_req, imem_addr, ir, pc, rf_rd_en, alu_src_imm, alu_valid,
           rf_we, rf_waddr, busy, halted, illegal, instret
  );

  modport slave (
    output start, imem_ack, imem_rdata, alu_ready,
    input  imem_req, imem_addr, ir, pc, rf_rd_en, alu_src_imm, alu_valid,
           rf_we, rf_waddr, busy, halted, illegal, instret
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// RV32 FETCH/DECODE/EXEC/WB sequencer, >=4 cycles per instruction; stalls on imem_ack and alu_ready.
// Optional retired-instruction counter built only when RV_CTRL_INSTRET_EN is defined.
module rv_multicycle_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  rv_multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            illegal_q, illegal_d;
  logic            alu_src_imm_q, alu_src_imm_d;
  logic [6:0]      opcode;
  logic            is_ecall;

  assign opcode   = ir_q[6:0];
  assign is_ecall = (opcode == 7'h73) && (ir_q[31:7] == 25'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      illegal_q     <= 1'b0;
      alu_src_imm_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      illegal_q     <= illegal_d;
      alu_src_imm_q <= alu_src_imm_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    illegal_d     = illegal_q;
    alu_src_imm_d = alu_src_imm_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          7'h13: begin alu_src_imm_d = 1'b1; state_d = S_EXEC; end
          7'h33: begin alu_src_imm_d = 1'b0; state_d = S_EXEC; end
          default: begin
            // ECALL halts cleanly; everything else (incl. other SYSTEM encodings) is illegal.
            if (!is_ecall) illegal_d = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_EXEC:   if (bus.alu_ready) state_d = S_WB;
      S_WB: begin
        pc_d    = pc_q + XLEN'(4);
        state_d = S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  assign bus.imem_req  = (state_q == S_FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.ir        = ir_q;
  assign bus.pc        = pc_q;
  assign bus.rf_rd_en  = (state_q == S_DECODE);
  assign bus.alu_valid = (state_q == S_EXEC);
  assign bus.rf_waddr  = ir_q[11:7];
  assign bus.rf_we     = (state_q == S_WB) && (ir_q[11:7] != 5'd0);
  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted    = (state_q == S_HALT);
  assign bus.illegal   = illegal_q;
  // Operand select is visible during DECODE already, then held from the register through EXEC/WB.
  assign bus.alu_src_imm = (state_q == S_DECODE) ? (opcode == 7'h13) : alu_src_imm_q;

`ifdef RV_CTRL_INSTRET_EN
  logic [31:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (state_q == S_WB) instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  assign bus.instret = instret_q;
`else
  assign bus.instret = 32'h0;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: two instances (RESET_PC = 0 and 32'hFFFF_FFFC).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_rv_multicycle_ctrl;

`ifdef RV_CTRL_INSTRET_EN
  localparam int INSTRET_STEP = 1;
`else
  localparam int INSTRET_STEP = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  rv_multicycle_ctrl_if #(.XLEN(32)) u_if ();
  rv_multicycle_ctrl_if #(.XLEN(32)) u_if2 ();

  rv_multicycle_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset), .bus(u_if.master)
  );
  rv_multicycle_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_dut2 (
    .clk(clk), .reset(reset), .bus(u_if2.master)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    u_if.start = 0; u_if.imem_ack = 0; u_if.alu_ready = 0;
    u_if2.start = 0; u_if2.imem_ack = 0; u_if2.alu_ready = 0;
    reset = 1;
    step();
    reset = 0;
    step();
  endtask

  // Plays memory and ALU for one instruction, starting with the DUT in FETCH.
  // Returns after WB (DUT back in FETCH) or once the DUT halts.
  task automatic run_instr(input logic [31:0] instr, input int ack_dly, input int rdy_dly,
                           output int n_req, output int n_alu, output int n_we, output int ncyc,
                           output logic [4:0] waddr, output logic src_dec, output logic src_wb,
                           output logic done);
    logic wb;
    n_req = 0; n_alu = 0; n_we = 0; ncyc = 0;
    waddr = '0; src_dec = 0; src_wb = 0; done = 0;
    u_if.imem_rdata = instr;
    for (int i = 0; i < 60 && !done; i++) begin
      ncyc++;
      if (u_if.imem_req) begin n_req++; u_if.imem_ack = (n_req > ack_dly); end
      else u_if.imem_ack = 0;
      if (u_if.rf_rd_en) src_dec = u_if.alu_src_imm;
      if (u_if.alu_valid) begin n_alu++; u_if.alu_ready = (n_alu > rdy_dly); end
      else u_if.alu_ready = 0;
      if (u_if.rf_we) n_we++;
      wb = u_if.busy && !u_if.imem_req && !u_if.rf_rd_en && !u_if.alu_valid;
      if (wb) begin waddr = u_if.rf_waddr; src_wb = u_if.alu_src_imm; end
      step();
      if (wb || u_if.halted) done = 1;
    end
    u_if.imem_ack = 0;
    u_if.alu_ready = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    step();
    total++; if (u_if.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", u_if.imem_req); end
    total++; if (u_if.busy !== 1'b0 || u_if.halted !== 1'b0) begin bad++; $display("FAIL reset_busy_halt got=%b%b exp=00", u_if.busy, u_if.halted); end
    total++; if (u_if.pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", u_if.pc); end
    total++; if (u_if.ir !== 32'h0 || u_if.illegal !== 1'b0 || u_if.alu_src_imm !== 1'b0) begin bad++; $display("FAIL reset_ir_ill_src got=%h/%b/%b exp=0/0/0", u_if.ir, u_if.illegal, u_if.alu_src_imm); end
    total++; if (u_if.instret !== 32'h0) begin bad++; $display("FAIL reset_instret got=%0d exp=0", u_if.instret); end
    total++; if (u_if2.pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL reset_pc2 got=%h exp=fffffffc", u_if2.pc); end
    reset = 0;
    step();
    total++; if (u_if.busy !== 1'b0) begin bad++; $display("FAIL idle_no_start got=%b exp=0", u_if.busy); end
  endtask

  task automatic test_addi;
    int n_req, n_alu, n_we, ncyc; logic [4:0] wa; logic sd, sw, dn;
    u_if.start = 1;
    step();
    u_if.start = 0;
    total++; if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h0) begin bad++; $display("FAIL addi_fetch got=%b/%h exp=1/0", u_if.imem_req, u_if.imem_addr); end
    run_instr(32'h0050_0093, 0, 0, n_req, n_alu, n_we, ncyc, wa, sd, sw, dn);
    total++; if (dn !== 1'b1 || ncyc != 4) begin bad++; $display("FAIL addi_cycles got=%b/%0d exp=1/4", dn, ncyc); end
    total++; if (n_req != 1 || n_alu != 1 || n_we != 1) begin bad++; $display("FAIL addi_strobes got=%0d/%0d/%0d exp=1/1/1", n_req, n_alu, n_we); end
    total++; if (sd !== 1'b1 || sw !== 1'b1) begin bad++; $display("FAIL addi_src got=%b/%b exp=1/1", sd, sw); end
    total++; if (wa !== 5'd1) begin bad++; $display("FAIL addi_waddr got=%0d exp=1", wa); end
    total++; if (u_if.pc !== 32'h4 || u_if.imem_addr !== 32'h4) begin bad++; $display("FAIL addi_pc got=%h/%h exp=4/4", u_if.pc, u_if.imem_addr); end
    total++; if (u_if.instret !== 32'(INSTRET_STEP)) begin bad++; $display("FAIL addi_instret got=%0d exp=%0d", u_if.instret, INSTRET_STEP); end
  endtask

  task automatic test_rtype_stalls;
    int n_req, n_alu, n_we, ncyc; logic [4:0] wa; logic sd, sw, dn;
    run_instr(32'h0020_81B3, 3, 2, n_req, n_alu, n_we, ncyc, wa, sd, sw, dn);
    total++; if (dn !== 1'b1 || ncyc != 9) begin bad++; $display("FAIL rtype_cycles got=%b/%0d exp=1/9", dn, ncyc); end
    total++; if (n_req != 4 || n_alu != 3 || n_we != 1) begin bad++; $display("FAIL rtype_strobes got=%0d/%0d/%0d exp=4/3/1", n_req, n_alu, n_we); end
    total++; if (sd !== 1'b0 || sw !== 1'b0) begin bad++; $display("FAIL rtype_src got=%b/%b exp=0/0", sd, sw); end
    total++; if (wa !== 5'd3) begin bad++; $display("FAIL rtype_waddr got=%0d exp=3", wa); end
    total++; if (u_if.pc !== 32'h8) begin bad++; $display("FAIL rtype_pc got=%h exp=8", u_if.pc); end
    total++; if (u_if.instret !== 32'(2 * INSTRET_STEP)) begin bad++; $display("FAIL rtype_instret got=%0d exp=%0d", u_if.instret, 2 * INSTRET_STEP); end
  endtask

  task automatic test_x0_dest;
    int n_req, n_alu, n_we, ncyc; logic [4:0] wa; logic sd, sw, dn;
    run_instr(32'h0000_0013, 0, 0, n_req, n_alu, n_we, ncyc, wa, sd, sw, dn);
    total++; if (dn !== 1'b1 || n_alu != 1 || n_we != 0) begin bad++; $display("FAIL x0_we got=%b/%0d/%0d exp=1/1/0", dn, n_alu, n_we); end
    total++; if (u_if.pc !== 32'hC) begin bad++; $display("FAIL x0_pc got=%h exp=c", u_if.pc); end
    total++; if (u_if.instret !== 32'(3 * INSTRET_STEP)) begin bad++; $display("FAIL x0_instret got=%0d exp=%0d", u_if.instret, 3 * INSTRET_STEP); end
  endtask

  task automatic test_ecall;
    int n_req, n_alu, n_we, ncyc; logic [4:0] wa; logic sd, sw, dn;
    run_instr(32'h0000_0073, 0, 0, n_req, n_alu, n_we, ncyc, wa, sd, sw, dn);
    total++; if (u_if.halted !== 1'b1 || u_if.illegal !== 1'b0 || u_if.busy !== 1'b0) begin bad++; $display("FAIL ecall_state got=%b/%b/%b exp=1/0/0", u_if.halted, u_if.illegal, u_if.busy); end
    total++; if (n_alu != 0 || n_we != 0 || u_if.pc !== 32'hC) begin bad++; $display("FAIL ecall_side got=%0d/%0d/%h exp=0/0/c", n_alu, n_we, u_if.pc); end
    u_if.start = 1;
    step(); step(); step();
    u_if.start = 0;
    total++; if (u_if.halted !== 1'b1 || u_if.imem_req !== 1'b0 || u_if.pc !== 32'hC) begin bad++; $display("FAIL ecall_start_ignored got=%b/%b/%h exp=1/0/c", u_if.halted, u_if.imem_req, u_if.pc); end
    total++; if (u_if.instret !== 32'(3 * INSTRET_STEP)) begin bad++; $display("FAIL ecall_instret got=%0d exp=%0d", u_if.instret, 3 * INSTRET_STEP); end
  endtask

  task automatic test_illegal;
    int n_req, n_alu, n_we, ncyc; logic [4:0] wa; logic sd, sw, dn;
    do_reset();
    u_if.start = 1; step(); u_if.start = 0;
    run_instr(32'h0000_0003, 0, 0, n_req, n_alu, n_we, ncyc, wa, sd, sw, dn);
    total++; if (u_if.halted !== 1'b1 || u_if.illegal !== 1'b1) begin bad++; $display("FAIL load_illegal got=%b/%b exp=1/1", u_if.halted, u_if.illegal); end
    total++; if (n_alu != 0 || n_we != 0 || u_if.pc !== 32'h0) begin bad++; $display("FAIL load_side got=%0d/%0d/%h exp=0/0/0", n_alu, n_we, u_if.pc); end
    do_reset();
    total++; if (u_if.illegal !== 1'b0) begin bad++; $display("FAIL illegal_cleared got=%b exp=0", u_if.illegal); end
    u_if.start = 1; step(); u_if.start = 0;
    run_instr(32'h0010_0073, 0, 0, n_req, n_alu, n_we, ncyc, wa, sd, sw, dn);
    total++; if (u_if.halted !== 1'b1 || u_if.illegal !== 1'b1) begin bad++; $display("FAIL ebreak_illegal got=%b/%b exp=1/1", u_if.halted, u_if.illegal); end
  endtask

  task automatic test_reset_mid_exec;
    do_reset();
    u_if.start = 1; step(); u_if.start = 0;
    u_if.imem_rdata = 32'h0050_0093; u_if.imem_ack = 1;
    step();
    u_if.imem_ack = 0;
    step();
    total++; if (u_if.alu_valid !== 1'b1 || u_if.alu_src_imm !== 1'b1) begin bad++; $display("FAIL mid_exec_reached got=%b/%b exp=1/1", u_if.alu_valid, u_if.alu_src_imm); end
    u_if.start = 1;
    reset = 1;
    #1;
    total++; if (u_if.alu_valid !== 1'b0 || u_if.imem_req !== 1'b0 || u_if.rf_rd_en !== 1'b0 || u_if.rf_we !== 1'b0) begin bad++; $display("FAIL mid_reset_strobes got=%b%b%b%b exp=0000", u_if.alu_valid, u_if.imem_req, u_if.rf_rd_en, u_if.rf_we); end
    total++; if (u_if.busy !== 1'b0 || u_if.pc !== 32'h0 || u_if.ir !== 32'h0 || u_if.alu_src_imm !== 1'b0) begin bad++; $display("FAIL mid_reset_state got=%b/%h/%h/%b exp=0/0/0/0", u_if.busy, u_if.pc, u_if.ir, u_if.alu_src_imm); end
    step();
    u_if.start = 0;
    reset = 0;
    step(); step();
    total++; if (u_if.busy !== 1'b0 || u_if.imem_req !== 1'b0) begin bad++; $display("FAIL mid_reset_idle got=%b/%b exp=0/0", u_if.busy, u_if.imem_req); end
  endtask

  task automatic test_pc_wrap;
    do_reset();
    u_if2.start = 1; step(); u_if2.start = 0;
    total++; if (u_if2.imem_req !== 1'b1 || u_if2.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_fetch got=%b/%h exp=1/fffffffc", u_if2.imem_req, u_if2.imem_addr); end
    u_if2.imem_rdata = 32'h0050_0093; u_if2.imem_ack = 1; u_if2.alu_ready = 1;
    step();
    u_if2.imem_ack = 0;
    step(); step();
    total++; if (u_if2.rf_we !== 1'b1 || u_if2.rf_waddr !== 5'd1) begin bad++; $display("FAIL wrap_wb got=%b/%0d exp=1/1", u_if2.rf_we, u_if2.rf_waddr); end
    step();
    u_if2.alu_ready = 0;
    total++; if (u_if2.pc !== 32'h0 || u_if2.imem_addr !== 32'h0 || u_if2.imem_req !== 1'b1) begin bad++; $display("FAIL wrap_pc got=%h/%h/%b exp=0/0/1", u_if2.pc, u_if2.imem_addr, u_if2.imem_req); end
    total++; if (u_if2.instret !== 32'(INSTRET_STEP)) begin bad++; $display("FAIL wrap_instret got=%0d exp=%0d", u_if2.instret, INSTRET_STEP); end
  endtask

  initial begin
    u_if.start = 0; u_if.imem_ack = 0; u_if.imem_rdata = '0; u_if.alu_ready = 0;
    u_if2.start = 0; u_if2.imem_ack = 0; u_if2.imem_rdata = '0; u_if2.alu_ready = 0;
    test_reset();
    test_addi();
    test_rtype_stalls();
    test_x0_dest();
    test_ecall();
    test_illegal();
    test_reset_mid_exec();
    test_pc_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
